// File: rtl/ws2811_receiver.sv
// WS2811 800 kHz NRZ receiver: decodes the first 24 bits after a reset gap into a GRB word and regenerates later bits downstream.
// Latency: 3 clkIN edges from a dataIN transition to any registered output (2-FF synchronizer plus output register).
// Backpressure: none; the line is free-running, and timing violations pulse errorOUT and wait for the next reset gap.
module ws2811_receiver #(
    parameter int CLOCK_SPEED  = 50_000_000,
    parameter int THRESHOLD_NS = 600,
    parameter int MIN_HIGH_NS  = 100,
    parameter int MAX_HIGH_NS  = 2000,
    parameter int RESET_NS     = 50_000
) (
    input  logic        clkIN,
    input  logic        resetIN,
    input  logic        dataIN,
    output logic [23:0] dataOUT,
    output logic        validOUT,
    output logic        forwardOUT,
    output logic        frameOUT,
    output logic        errorOUT
);

    // 64-bit intermediate: kHz * ns overflows 32 bits for the reset gap
    localparam longint KHZ        = longint'(CLOCK_SPEED / 1000);
    localparam int     THRESH_CYC = int'(KHZ * THRESHOLD_NS / 1_000_000);
    localparam int     MIN_CYC    = int'(KHZ * MIN_HIGH_NS / 1_000_000);
    localparam int     MAX_CYC    = int'(KHZ * MAX_HIGH_NS / 1_000_000);
    localparam int     RESET_CYC  = int'(KHZ * RESET_NS / 1_000_000);
    // one spare count so the low counter can park just past RESET_CYC
    localparam int     CW         = $clog2(RESET_CYC + 2);

    localparam logic [CW-1:0] THRESH_C  = CW'(THRESH_CYC);
    localparam logic [CW-1:0] MIN_C     = CW'(MIN_CYC);
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_CYC);
    localparam logic [CW-1:0] RESET_C   = CW'(RESET_CYC);
    localparam logic [CW-1:0] LOW_SAT_C = CW'(RESET_CYC + 1);

    typedef enum logic [1:0] {WAIT_RESET, IDLE, HIGH, FORWARD} state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [23:0]   shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d, forward_q, forward_d;
    logic          frame_q, frame_d, error_q, error_d;

    logic          rise, fall, gap;
    logic [23:0]   next_shift;

    assign rise       = s2_q & ~s3_q;
    assign fall       = ~s2_q & s3_q;
    // the low counter parks at RESET_CYC+1, so this is true for exactly one cycle per gap
    assign gap        = ~s2_q && (low_cnt_q == RESET_C);
    assign next_shift = {shift_q[22:0], (high_cnt_q >= THRESH_C)};

    assign dataOUT    = data_q;
    assign validOUT   = valid_q;
    assign forwardOUT = forward_q;
    assign frameOUT   = frame_q;
    assign errorOUT   = error_q;

    // synchronizer chain and saturating pulse-width counters
    always_comb begin
        s1_d       = dataIN;
        s2_d       = s1_q;
        s3_d       = s2_q;
        high_cnt_d = high_cnt_q;
        if (rise) begin
            high_cnt_d = CW'(1);
        end else if (s2_q && (high_cnt_q != '1)) begin
            high_cnt_d = high_cnt_q + CW'(1);
        end
        low_cnt_d = low_cnt_q;
        if (s2_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_SAT_C) begin
            low_cnt_d = low_cnt_q + CW'(1);
        end
    end

    // decoder FSM: next state, bit capture and output pulses
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        forward_d = 1'b0;
        frame_d   = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            WAIT_RESET: begin
                if (gap) begin
                    frame_d = 1'b1;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (gap) begin
                    // a gap part-way through a pixel means the word was truncated
                    frame_d   = 1'b1;
                    error_d   = (bit_cnt_q != 5'd0);
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (high_cnt_q < MIN_C) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        state_d   = WAIT_RESET;
                    end else begin
                        shift_d   = next_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            data_d  = next_shift;
                            valid_d = 1'b1;
                            state_d = FORWARD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (high_cnt_q >= MAX_C) begin
                    error_d   = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = WAIT_RESET;
                end
            end
            FORWARD: begin
                if (gap) begin
                    frame_d   = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = IDLE;
                end else begin
                    forward_d = s2_q;
                end
            end
            default: state_d = WAIT_RESET;
        endcase
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            state_q    <= WAIT_RESET;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            forward_q  <= 1'b0;
            frame_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            forward_q  <= forward_d;
            frame_q    <= frame_d;
            error_q    <= error_d;
        end
    end

endmodule
